// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO into a 2-entry output buffer and presents it as a
// valid/ready stream framed into fixed-length bursts (o_last on the final beat).
module fifo_stream_reader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_rd_en,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic [CNT_WIDTH-1:0]  o_beat_cnt
);

   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [CNT_WIDTH-1:0]  beat_q, beat_d;
   logic                  pop;
   logic [1:0]            occ_after_pop;
   logic [2:0]            owned;

   assign o_valid = (occ_q != 2'd0);
   assign pop     = o_valid & i_ready;

   // pop implies occ_q >= 1, so neither subtraction can underflow
   assign occ_after_pop = occ_q - {1'b0, pop};
   assign owned         = 3'(occ_after_pop) + 3'(inflight_q);

   assign o_fifo_rd_en = !i_rst & !i_fifo_empty & (owned < 3'd2);

   assign o_data     = head_q;
   assign o_last     = o_valid & (beat_q == LAST_BEAT);
   assign o_beat_cnt = beat_q;

   // Buffer shift/land and burst counter next state
   always_comb begin
      occ_d  = owned[1:0];
      head_d = head_q;
      tail_d = tail_q;
      beat_d = beat_q;

      if (pop && (occ_q == 2'd2)) begin
         head_d = tail_q;
      end

      if (inflight_q) begin
         if (occ_after_pop == 2'd0) begin
            head_d = i_fifo_data;
         end else begin
            tail_d = i_fifo_data;
         end
      end

      if (pop) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         beat_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= o_fifo_rd_en;
         head_q     <= head_d;
         tail_q     <= tail_d;
         beat_q     <= beat_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, words are
// queued as expected beats when written, and a negedge monitor checks every beat.
module tb_fifo_stream_reader;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [2:0] cnt;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_fifo_empty;
   logic [7:0] i_fifo_data = 8'h00;
   logic       o_fifo_rd_en;
   logic       o_valid;
   logic       i_ready = 1'b1;
   logic [7:0] o_data;
   logic       o_last;
   logic [2:0] o_beat_cnt;

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_data  (i_fifo_data),
      .o_fifo_rd_en (o_fifo_rd_en),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_last       (o_last),
      .o_beat_cnt   (o_beat_cnt)
   );

   always #5 i_clk = ~i_clk;

   int         errors = 0;
   int         checks = 0;
   exp_t       exp_q[$];
   logic [2:0] exp_idx = 3'd0;
   logic [7:0] mem[0:1023];
   int         wr_cnt = 0;
   int         rd_idx = 0;
   int         rd_cnt = 0;
   int         acc_cnt = 0;
   logic       rd_s = 1'b0;
   logic       hold_v = 1'b0;
   logic [7:0] hold_d;
   logic       hold_l;
   logic [2:0] hold_c;

   assign i_fifo_empty = (rd_idx >= wr_cnt);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.last = (exp_idx == 3'd3);
      e.cnt  = exp_idx;
      exp_q.push_back(e);
      exp_idx = (exp_idx == 3'd3) ? 3'd0 : exp_idx + 3'd1;
   endtask

   task automatic push_word(input logic [7:0] d);
      mem[wr_cnt] = d;
      wr_cnt++;
      exp_push(d);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   // FIFO model with registered read data
   always @(posedge i_clk) begin
      if (rd_s && !i_rst) begin
         i_fifo_data <= mem[rd_idx];
         rd_idx      <= rd_idx + 1;
      end
   end

   // Monitor: scoreboard, backpressure stability and occupancy bound
   always @(negedge i_clk) begin
      if (i_rst) begin
         rd_cnt  = 0;
         acc_cnt = 0;
         hold_v  = 1'b0;
      end else begin
         if (o_fifo_rd_en) rd_cnt++;
         if (!o_valid) chk("last_without_valid", 32'(o_last), 32'd0);
         if (hold_v) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_data", 32'(o_data), 32'(hold_d));
            chk("hold_last", 32'(o_last), 32'(hold_l));
            chk("hold_cnt", 32'(o_beat_cnt), 32'(hold_c));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", o_data, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("beat_data", 32'(o_data), 32'(e.data));
               chk("beat_last", 32'(o_last), 32'(e.last));
               chk("beat_cnt", 32'(o_beat_cnt), 32'(e.cnt));
            end
            acc_cnt++;
         end
         chk("occupancy_le_2", 32'((rd_cnt - acc_cnt) <= 2), 32'd1);
         hold_v = o_valid && !i_ready;
         hold_d = o_data;
         hold_l = o_last;
         hold_c = o_beat_cnt;
      end
      rd_s = o_fifo_rd_en && !i_rst;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      // Reset with FIFO loaded: no pops during reset, first pop right after release
      for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
      repeat (2) @(negedge i_clk);
      chk("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_cnt", 32'(o_beat_cnt), 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("first_rd_en", 32'(o_fifo_rd_en), 32'd1);
      chk("lat_valid_0", 32'(o_valid), 32'd0);
      @(negedge i_clk);
      chk("lat_valid_1", 32'(o_valid), 32'd0);
      @(negedge i_clk);
      chk("lat_valid_2", 32'(o_valid), 32'd1);
      chk("lat_data", 32'(o_data), 32'h11);

      // Full throughput: 8 beats on 8 consecutive clocks
      repeat (7) @(negedge i_clk);
      #1;
      chk("stream_8_beats", 32'(acc_cnt), 32'd8);
      tick();

      // Backpressure: only two pops issued, outputs held
      i_ready = 1'b0;
      base = rd_cnt;
      for (int i = 0; i < 6; i++) push_word(8'(8'h21 + i));
      repeat (6) @(negedge i_clk);
      #1;
      chk("bp_pops", 32'(rd_cnt - base), 32'd2);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_data", 32'(o_data), 32'h21);
      chk("bp_cnt", 32'(o_beat_cnt), 32'd0);
      chk("bp_last", 32'(o_last), 32'd0);
      tick();
      i_ready = 1'b1;
      base = acc_cnt;
      repeat (6) @(negedge i_clk);
      #1;
      chk("bp_release_no_gap", 32'(acc_cnt - base), 32'd6);
      tick();

      // FIFO empty mid-burst: stall with the beat counter held at 2
      repeat (3) begin
         @(negedge i_clk);
         chk("empty_valid", 32'(o_valid), 32'd0);
         chk("empty_cnt", 32'(o_beat_cnt), 32'd2);
      end
      tick();
      push_word(8'h31);
      push_word(8'h32);
      wait_drain(20);

      // Random backpressure over 256 beats
      for (int i = 0; i < 256; i++) push_word(8'(i * 7 + 3));
      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 4000) begin
            tick();
            i_ready = 1'($urandom_range(0, 1));
            n++;
         end
      end
      chk("random_drain", 32'(exp_q.size()), 32'd0);
      i_ready = 1'b1;
      tick();

      // Mid-operation reset with a word buffered and one in flight
      push_word(8'h40);
      wait_drain(20);
      i_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(8'(8'h41 + i));
      repeat (3) @(negedge i_clk);
      #1;
      chk("pre_rst_valid", 32'(o_valid), 32'd1);
      chk("pre_rst_data", 32'(o_data), 32'h41);
      chk("pre_rst_cnt", 32'(o_beat_cnt), 32'd1);
      i_rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_cnt", 32'(o_beat_cnt), 32'd0);
      chk("mid_rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
      chk("mid_rst_data", 32'(o_data), 32'd0);
      exp_q.delete();
      exp_idx = 3'd0;
      for (int k = rd_idx; k < wr_cnt; k++) exp_push(mem[k]);
      chk("mid_rst_remaining", 32'(exp_q.size()), 32'd4);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      i_ready = 1'b1;
      wait_drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
